// File: rtl/eth_pkg.sv
// eth_pkg: shared frame-building types, constants and byte helpers for the Ethernet TX/RX path
package eth_pkg;
    typedef enum logic [2:0] {IDLE, PRE, HDR, PAY, TAIL, DONE} state_t;
    localparam logic [31:0] PREAMBLE_WORD = 32'h55555555;
    localparam logic [31:0] SFD_WORD = 32'h5D555555;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam int MIN_PAYLOAD_WORDS = 12;
    function automatic logic [7:0] nibble_swap8(input logic [7:0] b);
        return {b[3:0], b[7:4]};
    endfunction
endpackage

// File: rtl/eth_word_packer.sv
// eth_word_packer: shifts a payload word stream up by two bytes behind a 16-bit head, with a flush word for the leftover carry
module eth_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] head,
    input  logic        sel_head,
    input  logic        advance,
    input  logic [31:0] word_in,
    output logic [31:0] word_out,
    output logic [31:0] flush_word
);
    logic [15:0] carry;
    // keep the upper two bytes of each consumed word for the next output word
    always_ff @(posedge clk) begin
        if (!rst_n) carry <= '0;
        else if (advance) carry <= word_in[31:16];
    end
    assign word_out = {word_in[15:0], sel_head ? head : carry};
    assign flush_word = {16'h0000, carry};
endmodule

// File: rtl/eth_frame_build.sv
// eth_frame_build: builds preamble/SFD, MAC header, EtherType and payload into TX frame RAM; ETH_FRAME_BUILD_PAD_EN pads short payloads to 12 words
module eth_frame_build
    import eth_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int MAX_PAYLOAD_WORDS = 506
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] payload_words,
    input  logic [47:0]       dst_mac,
    input  logic [47:0]       src_mac,
    input  logic [15:0]       eth_type,
    input  logic [31:0]       rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ena,
    output logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);
    state_t state, nstate;
    logic [ADDR_W-1:0] n, eff;
    logic [47:0] dst, src;
    logic [15:0] typ;
    logic [31:0] pack_out, flush_word, w2, w3, w4;
    logic adv, sel_head, accept, rd_fetch;

`ifdef ETH_FRAME_BUILD_PAD_EN
    assign eff = (n < ADDR_W'(MIN_PAYLOAD_WORDS)) ? ADDR_W'(MIN_PAYLOAD_WORDS) : n;
`else
    assign eff = n;
`endif

    assign accept = (state == IDLE) && start && (payload_words <= ADDR_W'(MAX_PAYLOAD_WORDS));
    assign rd_fetch = (state == PAY) || (state == HDR && wr_addr >= ADDR_W'(4));
    assign w2 = {nibble_swap8(dst[23:16]), nibble_swap8(dst[31:24]), nibble_swap8(dst[39:32]), nibble_swap8(dst[47:40])};
    assign w3 = {nibble_swap8(src[39:32]), nibble_swap8(src[47:40]), nibble_swap8(dst[7:0]), nibble_swap8(dst[15:8])};
    assign w4 = {nibble_swap8(src[7:0]), nibble_swap8(src[15:8]), nibble_swap8(src[23:16]), nibble_swap8(src[31:24])};
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign last_addr = done ? eff + ADDR_W'(5) : '0;

    // payload slots past the real length feed zeros instead of RAM data
    eth_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .head       ({nibble_swap8(typ[7:0]), nibble_swap8(typ[15:8])}),
        .sel_head   (sel_head),
        .advance    (adv),
        .word_in    ((wr_addr < n + ADDR_W'(5)) ? rd_data : 32'h0),
        .word_out   (pack_out),
        .flush_word (flush_word)
    );

    // state, latched request fields, write counter and read-ahead address
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            n <= '0;
            dst <= '0;
            src <= '0;
            typ <= '0;
            wr_addr <= '0;
            rd_addr <= '0;
            err <= 1'b0;
        end else begin
            state <= nstate;
            wr_addr <= wr_ena ? wr_addr + ADDR_W'(1) : '0;
            err <= (state == IDLE) && start && (payload_words > ADDR_W'(MAX_PAYLOAD_WORDS));
            if (accept) begin
                n <= payload_words;
                dst <= dst_mac;
                src <= src_mac;
                typ <= eth_type;
                rd_addr <= '0;
            end else if (rd_fetch && (rd_addr + ADDR_W'(1) < n)) begin
                rd_addr <= rd_addr + ADDR_W'(1);
            end
        end
    end

    // next state and per-word write data; reads run one word ahead of the packer
    always_comb begin
        nstate = state;
        wr_ena = 1'b0;
        wr_data = '0;
        adv = 1'b0;
        sel_head = 1'b0;
        case (state)
            IDLE: nstate = accept ? PRE : IDLE;
            PRE: begin
                wr_ena = 1'b1;
                wr_data = wr_addr[0] ? SFD_WORD : PREAMBLE_WORD;
                nstate = wr_addr[0] ? HDR : PRE;
            end
            HDR: begin
                wr_ena = 1'b1;
                wr_data = (wr_addr == ADDR_W'(2)) ? w2 : (wr_addr == ADDR_W'(3)) ? w3 : (wr_addr == ADDR_W'(4)) ? w4 : pack_out;
                if (wr_addr == ADDR_W'(5)) begin
                    adv = 1'b1;
                    sel_head = 1'b1;
                    nstate = (eff == '0) ? DONE : (eff == ADDR_W'(1)) ? TAIL : PAY;
                end
            end
            PAY: begin
                wr_ena = 1'b1;
                adv = 1'b1;
                wr_data = pack_out;
                nstate = (wr_addr == eff + ADDR_W'(4)) ? TAIL : PAY;
            end
            TAIL: begin
                wr_ena = 1'b1;
                wr_data = flush_word;
                nstate = DONE;
            end
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end
endmodule

// File: tb/tb_eth_frame_build.sv
// tb_eth_frame_build: randomized scoreboard bench for eth_frame_build against a byte-level frame model
module tb_eth_frame_build;
    import eth_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  payload_words = '0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] eth_type = '0;
    logic [31:0] rd_data;
    logic [8:0]  rd_addr, wr_addr, last_addr;
    logic [31:0] wr_data;
    logic        wr_ena, busy, done, err;

    eth_frame_build dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .payload_words (payload_words),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .eth_type      (eth_type),
        .rd_data       (rd_data),
        .rd_addr       (rd_addr),
        .wr_data       (wr_data),
        .wr_addr       (wr_addr),
        .wr_ena        (wr_ena),
        .last_addr     (last_addr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]  a;
        logic [31:0] d;
    } wr_t;
    wr_t        exp_wr[$];
    int         exp_done_cyc[$];
    logic [8:0] exp_last[$];
    int vecs = 0;
    int errs = 0;

    function automatic logic [7:0] swap_nib(input logic [7:0] b);
        return 8'((b << 4) | (b >> 4));
    endfunction

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // monitor: every write and every done pulse is matched against the scoreboard
    always @(negedge clk) begin
        wr_t e;
        if (wr_ena) begin
            vecs++;
            if (exp_wr.size() == 0) begin
                errs++;
                $display("FAIL unexpected_write addr=%0d data=%h", wr_addr, wr_data);
            end else begin
                e = exp_wr.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d) begin
                    errs++;
                    $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h", wr_addr, wr_data, e.a, e.d);
                end
            end
        end
        if (done) begin
            vecs++;
            if (exp_done_cyc.size() == 0) begin
                errs++;
                $display("FAIL unexpected_done last_addr=%0d", last_addr);
            end else begin
                int ec;
                logic [8:0] el;
                ec = exp_done_cyc.pop_front();
                el = exp_last.pop_front();
                if (last_addr !== el || cyc != ec || exp_wr.size() != 0) begin
                    errs++;
                    $display("FAIL done got last=%0d cyc=%0d pending=%0d want last=%0d cyc=%0d pending=0", last_addr, cyc, exp_wr.size(), el, ec);
                end
            end
        end
    end

    // issue one frame request, pushing its whole expected image; optionally fire a second start while busy
    task automatic send_frame(input int n, input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input bit dup, input bit wait_done);
        logic [7:0]  q[$];
        logic [31:0] w;
        int eff, st, tmo;
        eff = n;
`ifdef ETH_FRAME_BUILD_PAD_EN
        if (eff < 12) eff = 12;
`endif
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(swap_nib(8'hD5));
        for (int i = 0; i < 6; i++) q.push_back(swap_nib(d[47-8*i -: 8]));
        for (int i = 0; i < 6; i++) q.push_back(swap_nib(s[47-8*i -: 8]));
        q.push_back(swap_nib(t[15:8]));
        q.push_back(swap_nib(t[7:0]));
        for (int j = 0; j < eff; j++) begin
            w = (j < n) ? mem[j] : 32'h0;
            for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
        end
        q.push_back(8'h00);
        q.push_back(8'h00);
        for (int k = 0; k < eff + 6; k++) exp_wr.push_back('{a: 9'(k), d: {q[4*k+3], q[4*k+2], q[4*k+1], q[4*k]}});
        @(posedge clk);
        #1;
        start = 1'b1;
        payload_words = 9'(n);
        dst_mac = d;
        src_mac = s;
        eth_type = t;
        st = cyc;
        exp_done_cyc.push_back(st + eff + 7);
        exp_last.push_back(9'(eff + 5));
        @(posedge clk);
        #1;
        start = 1'b0;
        payload_words = 9'($urandom_range(0, 506));
        dst_mac = ~d;
        chk("busy_after_start", {47'h0, busy}, 48'h1);
        if (dup) begin
            @(posedge clk);
            #1;
            start = 1'b1;
            src_mac = ~s;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        if (wait_done) begin
            tmo = 0;
            while (exp_done_cyc.size() != 0 && tmo < eff + 40) begin
                @(posedge clk);
                tmo++;
            end
            if (exp_done_cyc.size() != 0) begin
                vecs++;
                errs++;
                $display("FAIL done_timeout pending_writes=%0d", exp_wr.size());
                exp_wr.delete();
                exp_done_cyc.delete();
                exp_last.delete();
            end
            @(posedge clk);
            #1;
            chk("busy_after_done", {47'h0, busy}, 48'h0);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 512; i++) mem[i] = $urandom();
    endtask

    task automatic rand_frame(input int n);
        fill_mem();
        send_frame(n, {16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, 16'($urandom()), 1'b0, 1'b1);
    endtask

    initial begin
        fill_mem();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_ena", {47'h0, wr_ena}, 48'h0);
        chk("rst_done", {47'h0, done}, 48'h0);
        chk("rst_busy", {47'h0, busy}, 48'h0);
        chk("rst_err", {47'h0, err}, 48'h0);
        chk("rst_rd_addr", {39'h0, rd_addr}, 48'h0);
        chk("rst_wr_addr", {39'h0, wr_addr}, 48'h0);
        chk("rst_last_addr", {39'h0, last_addr}, 48'h0);
        chk("rst_wr_data", {16'h0, wr_data}, 48'h0);
        rst_n = 1'b1;

        send_frame(0, 48'hFFFFFFFFFFFF, 48'h020000000001, ETHERTYPE_IPV4, 1'b0, 1'b1);
        mem[0] = 32'hDDCCBBAA;
        send_frame(1, 48'hFFFFFFFFFFFF, 48'h020000000001, ETHERTYPE_IPV4, 1'b0, 1'b1);
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        send_frame(3, 48'h0123456789AB, 48'hCAFEBABE0042, 16'h86DD, 1'b0, 1'b1);

        fill_mem();
        send_frame(5, {16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, 16'($urandom()), 1'b1, 1'b1);

        @(posedge clk);
        #1;
        start = 1'b1;
        payload_words = 9'd507;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("err_pulse", {47'h0, err}, 48'h1);
        chk("err_busy", {47'h0, busy}, 48'h0);
        @(posedge clk);
        #1;
        chk("err_one_cycle", {47'h0, err}, 48'h0);
        chk("err_busy_later", {47'h0, busy}, 48'h0);

        fill_mem();
        send_frame(20, {16'($urandom()), $urandom()}, {16'($urandom()), $urandom()}, 16'($urandom()), 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_wr_ena", {47'h0, wr_ena}, 48'h0);
        chk("abort_done", {47'h0, done}, 48'h0);
        chk("abort_busy", {47'h0, busy}, 48'h0);
        exp_wr.delete();
        exp_done_cyc.delete();
        exp_last.delete();
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        rand_frame(20);

        rand_frame(2);
        rand_frame(11);
        rand_frame(12);
        rand_frame(506);
        for (int i = 0; i < 20; i++) rand_frame(int'($urandom_range(0, 40)));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
